// File: rtl/dds_pkg.sv
// Shared definitions for the multi-channel DDS lookup engine.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: quadrant encoding, channel-index width helper, quarter-wave
// address folding and sign selection.
package dds_pkg;

    // Quadrant is the top two phase bits.
    typedef enum logic [1:0] {
        Q0 = 2'd0,   // 0    .. pi/2   : rising,  positive
        Q1 = 2'd1,   // pi/2 .. pi     : falling, positive
        Q2 = 2'd2,   // pi   .. 3pi/2  : falling, negative
        Q3 = 2'd3    // 3pi/2.. 2pi    : rising,  negative
    } quad_t;

    // Widest ROM address the folding helper handles.
    localparam int MAX_ADDR_W = 32;

    // Channel-index width; a single channel still gets a 1-bit index.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Odd quadrants walk the quarter table backwards. The table is sampled at
    // half-step offsets, so bitwise inversion is an exact mirror.
    function automatic logic [MAX_ADDR_W-1:0] fold_addr(input logic [MAX_ADDR_W-1:0] idx,
                                                        input logic [1:0]            q);
        return (q == Q1 || q == Q3) ? ~idx : idx;
    endfunction

    // Lower half of the circle carries a negative sample.
    function automatic logic is_neg(input logic [1:0] q);
        return (q == Q2 || q == Q3);
    endfunction

endpackage

// File: rtl/dds_lut_engine_if.sv
// Control, ROM and sample bus of the DDS lookup engine.
// Latency: n/a (wiring only).
// Backpressure: none; samples are strobed by out_valid, and the engine stalls only via en.
//
// slave  : the engine side (consumes control and ROM data, drives addresses and samples)
// master : the surrounding logic (register block, ROM, mixers/DAC formatter)
interface dds_lut_engine_if #(
    parameter int NCH     = 4,
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 11,
    parameter int AMP_W   = 24,
    parameter int OUT_W   = 32
);
    localparam int CW = dds_pkg::ch_w(NCH);

    logic               en;
    logic               clr;
    logic               ftw_wr;
    logic [CW-1:0]      ftw_ch;
    logic [PHASE_W-1:0] ftw_data;
    logic [ADDR_W-1:0]  rom_addr_a;
    logic [ADDR_W-1:0]  rom_addr_b;
    logic [AMP_W-1:0]   rom_data_a;
    logic [AMP_W-1:0]   rom_data_b;
    logic               out_valid;
    logic [CW-1:0]      out_ch;
    logic [OUT_W-1:0]   sin_out;
    logic [OUT_W-1:0]   cos_out;

    modport master (
        output en, clr, ftw_wr, ftw_ch, ftw_data, rom_data_a, rom_data_b,
        input  rom_addr_a, rom_addr_b, out_valid, out_ch, sin_out, cos_out
    );

    modport slave (
        input  en, clr, ftw_wr, ftw_ch, ftw_data, rom_data_a, rom_data_b,
        output rom_addr_a, rom_addr_b, out_valid, out_ch, sin_out, cos_out
    );

endinterface

// File: rtl/dds_delay_line.sv
// Fixed-depth shift register that carries per-sample side info next to the ROM pipeline.
// Latency: D clocks from d to q.
// Backpressure: none; it shifts every clock so in-flight samples always drain.
//
// Ports: clk, rst_n (async active-low), d [W] in, q [W] out.
module dds_delay_line #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sr [D];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[D-1];

endmodule

// File: rtl/dds_lut_engine.sv
// Time-multiplexed multi-channel DDS: phase accumulators, quarter-wave fold, sign restore.
// Latency: ROM_LAT+1 clocks from slot to sample; one sample per clock.
// Backpressure: none downstream; en=0 or clr=1 inserts bubbles while in-flight samples drain.
//
// Ports: Fg_CLK, RESETn (async active-low), bus (dds_lut_engine_if.slave):
//   en/clr/ftw_wr/ftw_ch/ftw_data in, rom_addr_a/b out, rom_data_a/b in,
//   out_valid/out_ch/sin_out/cos_out out.
module dds_lut_engine
    import dds_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 11,
    parameter int AMP_W   = 24,
    parameter int OUT_W   = 32,
    parameter int ROM_LAT = 2
) (
    input  logic             Fg_CLK,
    input  logic             RESETn,
    dds_lut_engine_if.slave  bus
);

    localparam int CW = ch_w(NCH);
    // valid, channel, sine sign, cosine sign
    localparam int SW = 1 + CW + 2;

    logic [PHASE_W-1:0] ftw [NCH];
    logic [PHASE_W-1:0] acc [NCH];
    logic [CW-1:0]      ch_cnt;

    logic               slot;
    logic [PHASE_W-1:0] p_sum;
    logic [1:0]         q_sin;
    logic [1:0]         q_cos;
    logic [ADDR_W-1:0]  idx;

    logic               s0_vld;
    logic [CW-1:0]      s0_ch;
    logic               s0_neg_a;
    logic               s0_neg_b;

    logic [SW-1:0]      dl_q;
    logic               d_vld;
    logic [CW-1:0]      d_ch;
    logic               d_neg_a;
    logic               d_neg_b;

    logic signed [AMP_W:0] mag_a;
    logic signed [AMP_W:0] mag_b;
    logic signed [AMP_W:0] sv_a;
    logic signed [AMP_W:0] sv_b;

    // clr wins over en and suppresses the slot.
    assign slot  = bus.en & ~bus.clr;
    // The freshly accumulated phase is what gets looked up this clock.
    assign p_sum = acc[ch_cnt] + ftw[ch_cnt];
    assign q_sin = p_sum[PHASE_W-1 -: 2];
    assign q_cos = q_sin + 2'd1;
    assign idx   = p_sum[PHASE_W-3 -: ADDR_W];

    // Tuning words and accumulators. A write landing on the channel being
    // slotted takes effect on that channel's next slot, since p_sum reads the
    // old register value.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < NCH; i++) begin
                ftw[i] <= '0;
                acc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                // ftw_ch values >= NCH match no entry and are dropped.
                if (bus.ftw_wr && bus.ftw_ch == CW'(i))
                    ftw[i] <= bus.ftw_data;
                if (bus.clr)
                    acc[i] <= '0;
                else if (slot && ch_cnt == CW'(i))
                    acc[i] <= p_sum;
            end
        end
    end

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn)
            ch_cnt <= '0;
        else if (bus.clr)
            ch_cnt <= '0;
        else if (slot)
            ch_cnt <= (ch_cnt == CW'(NCH-1)) ? '0 : ch_cnt + 1'b1;
    end

    // Stage 0: registered ROM addresses and the side info that must travel
    // alongside the ROM read.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            bus.rom_addr_a <= '0;
            bus.rom_addr_b <= '0;
            s0_vld         <= 1'b0;
            s0_ch          <= '0;
            s0_neg_a       <= 1'b0;
            s0_neg_b       <= 1'b0;
        end else begin
            s0_vld <= slot;
            if (slot) begin
                bus.rom_addr_a <= ADDR_W'(fold_addr(MAX_ADDR_W'(idx), q_sin));
                bus.rom_addr_b <= ADDR_W'(fold_addr(MAX_ADDR_W'(idx), q_cos));
                s0_ch          <= ch_cnt;
                s0_neg_a       <= is_neg(q_sin);
                s0_neg_b       <= is_neg(q_cos);
            end
        end
    end

    dds_delay_line #(
        .W (SW),
        .D (ROM_LAT)
    ) u_align (
        .clk   (Fg_CLK),
        .rst_n (RESETn),
        .d     ({s0_vld, s0_ch, s0_neg_a, s0_neg_b}),
        .q     (dl_q)
    );

    assign {d_vld, d_ch, d_neg_a, d_neg_b} = dl_q;

    // Negate in AMP_W+1 bits so a full-scale magnitude never overflows.
    assign mag_a = {1'b0, bus.rom_data_a};
    assign mag_b = {1'b0, bus.rom_data_b};
    assign sv_a  = d_neg_a ? -mag_a : mag_a;
    assign sv_b  = d_neg_b ? -mag_b : mag_b;

    // Output stage; sample fields hold across bubbles.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            bus.out_valid <= 1'b0;
            bus.out_ch    <= '0;
            bus.sin_out   <= '0;
            bus.cos_out   <= '0;
        end else begin
            bus.out_valid <= d_vld;
            if (d_vld) begin
                bus.out_ch  <= d_ch;
                bus.sin_out <= {{(OUT_W-AMP_W){sv_a[AMP_W]}}, sv_a[AMP_W-1:0]};
                bus.cos_out <= {{(OUT_W-AMP_W){sv_b[AMP_W]}}, sv_b[AMP_W-1:0]};
            end
        end
    end

endmodule

// File: tb/tb_dds_lut_engine.sv
// Self-checking bench for dds_lut_engine: a single-channel instance driven from a
// cycle table, and a four-channel instance checked cycle by cycle against a scoreboard.
// Both instances use a pipelined ROM model holding rom[k] = k+1.
module tb_dds_lut_engine;

    localparam int ROM_LAT = 2;
    localparam int PL      = ROM_LAT + 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dds_lut_engine_if #(.NCH(4)) bus4();
    dds_lut_engine_if #(.NCH(1)) bus1();

    dds_lut_engine #(.NCH(4), .ROM_LAT(ROM_LAT)) u4 (
        .Fg_CLK (clk),
        .RESETn (rst_n),
        .bus    (bus4)
    );

    dds_lut_engine #(.NCH(1), .ROM_LAT(ROM_LAT)) u1 (
        .Fg_CLK (clk),
        .RESETn (rst_n),
        .bus    (bus1)
    );

    // ROM models: registered, ROM_LAT clocks from address to data.
    logic [23:0] r4a [ROM_LAT];
    logic [23:0] r4b [ROM_LAT];
    logic [23:0] r1a [ROM_LAT];
    logic [23:0] r1b [ROM_LAT];

    always @(posedge clk) begin
        r4a[0] <= 24'(bus4.rom_addr_a) + 24'd1;
        r4b[0] <= 24'(bus4.rom_addr_b) + 24'd1;
        r1a[0] <= 24'(bus1.rom_addr_a) + 24'd1;
        r1b[0] <= 24'(bus1.rom_addr_b) + 24'd1;
        for (int i = 1; i < ROM_LAT; i++) begin
            r4a[i] <= r4a[i-1];
            r4b[i] <= r4b[i-1];
            r1a[i] <= r1a[i-1];
            r1b[i] <= r1b[i-1];
        end
    end

    assign bus4.rom_data_a = r4a[ROM_LAT-1];
    assign bus4.rom_data_b = r4b[ROM_LAT-1];
    assign bus1.rom_data_a = r1a[ROM_LAT-1];
    assign bus1.rom_data_b = r1b[ROM_LAT-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected sample from phase p with a quarter ROM of 2048 entries, rom[k]=k+1.
    function automatic logic [31:0] exp_val(input logic [31:0] p, input bit is_cos);
        logic [1:0]  q;
        logic [10:0] ix;
        int          k;
        q  = p[31:30] + (is_cos ? 2'd1 : 2'd0);
        ix = p[29:19];
        k  = q[0] ? (2047 - int'(ix)) : int'(ix);
        return (q >= 2'd2) ? -32'(k + 1) : 32'(k + 1);
    endfunction

    // Scoreboard for the four-channel instance.
    typedef struct packed {
        logic        vld;
        logic [1:0]  ch;
        logic [31:0] s;
        logic [31:0] c;
    } exp_t;

    exp_t        pipe [PL];
    logic [31:0] macc [4];
    logic [31:0] mftw [4];
    logic [1:0]  mch;
    logic [1:0]  hch;
    logic [31:0] hs;
    logic [31:0] hc;
    logic [31:0] mp;
    exp_t        e;

    always begin
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                macc[i] = '0;
                mftw[i] = '0;
            end
            for (int i = 0; i < PL; i++) pipe[i] = '0;
            mch = '0;
            hch = '0;
            hs  = '0;
            hc  = '0;
        end else begin
            for (int i = PL - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = '0;
            if (bus4.clr) begin
                for (int i = 0; i < 4; i++) macc[i] = '0;
                mch = '0;
            end else if (bus4.en) begin
                mp        = macc[mch] + mftw[mch];
                macc[mch] = mp;
                pipe[0]   = '{vld: 1'b1, ch: mch, s: exp_val(mp, 1'b0), c: exp_val(mp, 1'b1)};
                mch       = mch + 2'd1;
            end
            if (bus4.ftw_wr) mftw[bus4.ftw_ch] = bus4.ftw_data;
        end
        #2;
        e = pipe[PL-1];
        if (e.vld) begin
            hch = e.ch;
            hs  = e.s;
            hc  = e.c;
        end
        chk("stream4", 72'({bus4.out_valid, bus4.out_ch, bus4.sin_out, bus4.cos_out}),
            72'({e.vld, hch, hs, hc}));
    end

    typedef struct {
        logic        en;
        logic        vld;
        logic [31:0] s;
        logic [31:0] c;
    } vec_t;

    vec_t tab [12];

    initial begin
        // Single channel, ftw = 2^30: phases cycle through the four quadrant starts.
        tab[0]  = '{1'b1, 1'b0, 32'h0,        32'h0};
        tab[1]  = '{1'b1, 1'b0, 32'h0,        32'h0};
        tab[2]  = '{1'b1, 1'b0, 32'h0,        32'h0};
        tab[3]  = '{1'b1, 1'b1, 32'h800,      32'hFFFF_FFFF};
        tab[4]  = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_F800};
        tab[5]  = '{1'b1, 1'b1, 32'hFFFF_F800, 32'h1};
        tab[6]  = '{1'b0, 1'b1, 32'h1,        32'h800};
        tab[7]  = '{1'b1, 1'b0, 32'h1,        32'h800};
        tab[8]  = '{1'b0, 1'b1, 32'h800,      32'hFFFF_FFFF};
        tab[9]  = '{1'b0, 1'b0, 32'h800,      32'hFFFF_FFFF};
        tab[10] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_F800};
        tab[11] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_F800};

        rst_n = 1'b0;
        bus4.en = 1'b0; bus4.clr = 1'b0; bus4.ftw_wr = 1'b0; bus4.ftw_ch = '0; bus4.ftw_data = '0;
        bus1.en = 1'b0; bus1.clr = 1'b0; bus1.ftw_wr = 1'b0; bus1.ftw_ch = '0; bus1.ftw_data = '0;
        repeat (3) tick();

        chk("rst_out4",  72'({bus4.out_valid, bus4.out_ch, bus4.sin_out, bus4.cos_out}), 72'h0);
        chk("rst_addr4", 72'({bus4.rom_addr_a, bus4.rom_addr_b}), 72'h0);
        chk("rst_out1",  72'({bus1.out_valid, bus1.out_ch, bus1.sin_out, bus1.cos_out}), 72'h0);

        rst_n = 1'b1;
        tick();

        // Quadrant walk and en bubbles on the single-channel instance.
        bus1.ftw_wr = 1'b1; bus1.ftw_ch = 1'b0; bus1.ftw_data = 32'h4000_0000;
        tick();
        bus1.ftw_wr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus1.en = tab[i].en;
            tick();
            chk($sformatf("t1_vec%0d", i),
                72'({bus1.out_valid, bus1.out_ch, bus1.sin_out, bus1.cos_out}),
                72'({tab[i].vld, 1'b0, tab[i].s, tab[i].c}));
        end
        bus1.en = 1'b0;

        // Write to a nonexistent channel must not disturb ftw[0].
        bus1.ftw_wr = 1'b1; bus1.ftw_ch = 1'b1; bus1.ftw_data = 32'h0;
        tick();
        bus1.ftw_wr = 1'b0;
        bus1.en = 1'b1;
        tick();
        bus1.en = 1'b0;
        repeat (ROM_LAT + 1) tick();
        chk("t1_badch", 72'({bus1.out_valid, bus1.sin_out, bus1.cos_out}),
            72'({1'b1, 32'hFFFF_F800, 32'h1}));

        // Four channels with distinct tuning words, long run.
        bus4.ftw_wr = 1'b1;
        bus4.ftw_ch = 2'd0; bus4.ftw_data = 32'h0123_4567; tick();
        bus4.ftw_ch = 2'd1; bus4.ftw_data = 32'h89AB_CDEF; tick();
        bus4.ftw_ch = 2'd2; bus4.ftw_data = 32'h1000_0001; tick();
        bus4.ftw_ch = 2'd3; bus4.ftw_data = 32'hFEDC_BA98; tick();
        bus4.ftw_wr = 1'b0;
        bus4.en = 1'b1;
        repeat (1000) tick();

        // Tuning-word write on channel 2's own slot.
        for (int k = 0; k < 8 && mch != 2'd2; k++) tick();
        bus4.ftw_wr = 1'b1; bus4.ftw_ch = 2'd2; bus4.ftw_data = 32'h0400_0000;
        tick();
        bus4.ftw_wr = 1'b0;
        repeat (20) tick();

        // Alternating en.
        for (int i = 0; i < 40; i++) begin
            bus4.en = (i % 2 == 0);
            tick();
        end
        bus4.en = 1'b1;
        repeat (10) tick();

        // clr mid-stream, then wrap with ftw[0] = all ones.
        bus4.ftw_wr = 1'b1; bus4.ftw_ch = 2'd0; bus4.ftw_data = 32'hFFFF_FFFF;
        tick();
        bus4.ftw_wr = 1'b0;
        repeat (5) tick();
        bus4.clr = 1'b1;
        tick();
        bus4.clr = 1'b0;
        tick();
        chk("t5_first_addr", 72'({bus4.rom_addr_a, bus4.rom_addr_b}), 72'({11'd0, 11'd2047}));
        repeat (20) tick();

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #2;
        chk("t6_async_out4",  72'({bus4.out_valid, bus4.out_ch, bus4.sin_out, bus4.cos_out}), 72'h0);
        chk("t6_async_addr4", 72'({bus4.rom_addr_a, bus4.rom_addr_b}), 72'h0);
        chk("t6_async_out1",  72'({bus1.out_valid, bus1.sin_out, bus1.cos_out}), 72'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        repeat (ROM_LAT + 1) tick();
        chk("t6_after_rst", 72'({bus4.out_valid, bus4.out_ch, bus4.sin_out, bus4.cos_out}),
            72'({1'b1, 2'd0, 32'h1, 32'h800}));
        repeat (10) tick();
        bus4.en = 1'b0;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_lut_engine.md
Name: dds_lut_engine

Overview:
- Time-multiplexed, multi-channel DDS engine: per-channel phase accumulator, quarter-wave folding, external dual-port quarter-sine ROM, sign restoration.
- Produces signed sine and cosine samples tagged with a channel number and a valid strobe.
- Sits between the frequency-control register interface and the waveform mixers/DAC formatter.
- Generalises the existing single-address coefficient lookup: channel count, phase/address/amplitude widths and ROM latency are parametrised.

Parameters:
- NCH, 4, number of time-multiplexed channels (1..16)
- PHASE_W, 32, phase accumulator and tuning-word width
- ADDR_W, 11, quarter-wave ROM address width (PHASE_W >= ADDR_W+2)
- AMP_W, 24, unsigned ROM magnitude width
- OUT_W, 32, output sample width (OUT_W >= AMP_W+1)
- ROM_LAT, 2, ROM read latency in clocks, from address to data (>= 1)

Ports:
- Fg_CLK  in  1  system clock
- RESETn  in  1  asynchronous active-low reset
- en  in  1  advance sequencer/accumulators; 0 freezes the sequencer
- clr  in  1  synchronous clear of all accumulators and the channel counter
- ftw_wr  in  1  tuning-word write strobe
- ftw_ch  in  $clog2(NCH) (min 1)  channel written
- ftw_data  in  PHASE_W  frequency tuning word
- rom_addr_a  out  ADDR_W  sine lookup address, registered
- rom_addr_b  out  ADDR_W  cosine lookup address, registered
- rom_data_a  in  AMP_W  magnitude for port a, ROM_LAT clocks after the address
- rom_data_b  in  AMP_W  magnitude for port b
- out_valid  out  1  sample valid
- out_ch  out  $clog2(NCH) (min 1)  channel of the sample
- sin_out  out  OUT_W  signed sine sample
- cos_out  out  OUT_W  signed cosine sample

Behaviour:
- Reset (async, RESETn=0): all ftw, acc, ch counter, rom_addr_a/b, pipeline valid/ch/sign, out_valid, out_ch, sin_out, cos_out = 0.
- Slot: each clock with en=1 (and clr=0), ch = counter.
  - acc[ch] <= acc[ch] + ftw[ch] (mod 2^PHASE_W).
  - The new sum p is looked up in the same clock; the counter wraps NCH-1 -> 0.
- en=0: no slot issued, counter and acc hold; in-flight samples still drain, so invalid bubbles are inserted.
- clr=1: acc[*] = 0 and counter = 0; no slot is issued that cycle. In-flight samples still drain. clr has priority over en.
- Fold: q = p[PHASE_W-1:PHASE_W-2]; idx = p[PHASE_W-3 -: ADDR_W].
  - q=0: addr = idx, positive.
  - q=1: addr = ~idx, positive.
  - q=2: addr = idx, negative.
  - q=3: addr = ~idx, negative.
  - Sine uses q; cosine uses q+1 (mod 4) with the same idx.
  - The ROM holds sin(2*pi*(k+0.5)/(4*2^ADDR_W)), so ~idx is an exact mirror.
- Pipeline:
  - Stage 0 registers rom_addr_a/b plus the valid, ch and two sign bits.
  - Valid, ch and sign are delayed ROM_LAT cycles to align with rom_data.
  - Output stage registers sin_out = neg ? -mag : +mag, computed in AMP_W+1 bits and sign-extended to OUT_W; likewise cos_out.
- Latency: slot clock to out_valid = ROM_LAT+1 clocks. Throughput is one sample per clock.
- out_valid=0 cycles: sin_out/cos_out/out_ch hold their last values.
- ftw write: ftw[ftw_ch] <= ftw_data.
  - Simultaneous write and slot on the same channel: the accumulation uses the old ftw; the new value takes effect on the next slot of that channel.
  - ftw_ch >= NCH: the write is ignored.
- Mid-operation reset: everything is cleared immediately. The first slot follows the first clock with RESETn=1 and en=1.

Decomposition:
- Package dds_pkg:
  - quadrant encoding constants
  - function fold_addr(idx, q)
  - function is_neg(q)
  - localparam CH_W = (NCH>1) ? $clog2(NCH) : 1
- One natural sub-module, dds_delay_line: parametrised width/depth shift register for the valid/ch/sign alignment (depth ROM_LAT).
- The accumulator bank and output stage stay in the top module.

Test Plan:
1. NCH=1, ftw=2^30, en=1, ROM model rom[k]=k+1:
   - phases are 2^30, 2^31, 3*2^30, 0, ...
   - Sample 1: sin_out=+rom[2047]=+2048, cos_out=-rom[0]=-1.
   - Sample 2: sin=-1, cos=-2048.
   - Sample 3: sin=-2048, cos=+1.
   - Sample 4: sin=+1, cos=+2048.
   - Each sample appears ROM_LAT+1 clocks after its slot.
2. NCH=4, distinct ftw per channel:
   - out_ch sequence is 0,1,2,3,0,...
   - Each channel's acc advances only in its own slot; compare against a per-channel golden accumulator over 1000 cycles.
3. ftw write to ch2 on ch2's slot clock:
   - that sample uses the old increment; the next ch2 slot uses the new one.
4. en pulsed 1/0 alternately:
   - out_valid follows the pattern delayed by ROM_LAT+1.
   - No samples are lost or duplicated; outputs hold during bubbles.
5. clr asserted mid-stream:
   - in-flight samples still emerge.
   - The next issued slot is ch0 with phase = ftw[0].
   - acc overflow wrap is checked: ftw=0xFFFF_FFFF yields p = -1, -2, ... (mod 2^32).
6. RESETn dropped asynchronously between clock edges mid-stream:
   - outputs, rom_addr and out_valid go to 0 before the next edge.
   - After release: ftw=0, so every sample is sin=+rom[0], cos=+rom[2047].
